imm_gen_pipe: RTL and testbench

//  Pipelined, parametrised RV immediate generator. Sits between fetch and decode/ALU-operand select.

---
 rtl/imm_gen_pkg.sv | 37 +++
 rtl/imm_decode.sv | 66 ++++++
 rtl/imm_gen_pipe.sv | 149 ++++++++++++++
 tb/tb_imm_gen_pipe.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_gen_pkg.sv
// Shared types, opcode constants and sign-extension helper for the RV immediate generator.
package imm_gen_pkg;

  localparam int unsigned INST_W = 32;
  localparam int unsigned OPC_W  = 7;
  localparam int unsigned F3_W   = 3;

  typedef enum logic [2:0] {
    FMT_R     = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_SHAMT = 3'd6,
    FMT_NONE  = 3'd7
  } imm_fmt_e;

  localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;

  localparam logic [F3_W-1:0] F3_SLLI = 3'b001;
  localparam logic [F3_W-1:0] F3_SRXI = 3'b101;

  // Callers pre-extend to 32 bits; this widens to the 64-bit maximum datapath.
  function automatic logic [63:0] sext(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational RV immediate decoder: instruction word -> immediate, format tag, illegal flag.
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [INST_W-1:0] inst,
  output logic [XLEN-1:0]   imm,
  output imm_fmt_e          fmt,
  output logic              illegal
);

  logic [OPC_W-1:0] opcode;
  logic [F3_W-1:0]  funct3;
  logic [63:0]      imm_w;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];

  always_comb begin
    imm_w   = '0;
    fmt     = FMT_NONE;
    illegal = 1'b0;
    case (opcode)
      OPC_OP_IMM: begin
        if (funct3 == F3_SLLI || funct3 == F3_SRXI) begin
          // RV64 shifts take a 6-bit shamt, RV32 only 5 bits
          fmt   = FMT_SHAMT;
          imm_w = (XLEN == 64) ? {58'b0, inst[25:20]} : {59'b0, inst[24:20]};
        end else begin
          fmt   = FMT_I;
          imm_w = sext({{20{inst[31]}}, inst[31:20]});
        end
      end
      OPC_LOAD, OPC_JALR: begin
        fmt   = FMT_I;
        imm_w = sext({{20{inst[31]}}, inst[31:20]});
      end
      OPC_STORE: begin
        fmt   = FMT_S;
        imm_w = sext({{20{inst[31]}}, inst[31:25], inst[11:7]});
      end
      OPC_BRANCH: begin
        fmt   = FMT_B;
        imm_w = sext({{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0});
      end
      OPC_LUI, OPC_AUIPC: begin
        fmt   = FMT_U;
        imm_w = sext({inst[31:12], 12'b0});
      end
      OPC_JAL: begin
        fmt   = FMT_J;
        imm_w = sext({{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0});
      end
      OPC_OP: begin
        fmt = FMT_R;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

  assign imm = XLEN'(imm_w);

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined RV immediate generator with valid/ready and a 2-entry (output + skid) buffer.
// Optional IMM_GEN_PERF_EN adds saturating output-handshake counters perf_total / perf_illegal.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INST_W-1:0] in_inst,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_imm,
  output imm_fmt_e          out_fmt,
  output logic              out_illegal,
  output logic [TAG_W-1:0]  out_tag
`ifdef IMM_GEN_PERF_EN
  ,
  output logic [31:0]       perf_total,
  output logic [31:0]       perf_illegal
`endif
);

  if (XLEN != 32 && XLEN != 64) begin : g_xlen_chk
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  logic [XLEN-1:0]  dec_imm;
  imm_fmt_e         dec_fmt;
  logic             dec_illegal;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .inst    (in_inst),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_illegal)
  );

  logic             skid_full, skid_full_n;
  logic [XLEN-1:0]  skid_imm, skid_imm_n;
  imm_fmt_e         skid_fmt, skid_fmt_n;
  logic             skid_illegal, skid_illegal_n;
  logic [TAG_W-1:0] skid_tag, skid_tag_n;

  logic             out_valid_n, in_ready_n, out_illegal_n;
  logic [XLEN-1:0]  out_imm_n;
  imm_fmt_e         out_fmt_n;
  logic [TAG_W-1:0] out_tag_n;
  logic             acc_in;

  assign acc_in = in_valid && in_ready;

  // Next-state for output and skid stages; flush wins over every handshake.
  always_comb begin
    out_valid_n    = out_valid;
    out_imm_n      = out_imm;
    out_fmt_n      = out_fmt;
    out_illegal_n  = out_illegal;
    out_tag_n      = out_tag;
    skid_full_n    = skid_full;
    skid_imm_n     = skid_imm;
    skid_fmt_n     = skid_fmt;
    skid_illegal_n = skid_illegal;
    skid_tag_n     = skid_tag;
    if (flush) begin
      out_valid_n = 1'b0;
      skid_full_n = 1'b0;
    end else if (out_valid && !out_ready) begin
      if (acc_in) begin
        skid_full_n    = 1'b1;
        skid_imm_n     = dec_imm;
        skid_fmt_n     = dec_fmt;
        skid_illegal_n = dec_illegal;
        skid_tag_n     = in_tag;
      end
    end else if (skid_full) begin
      // in_ready is low whenever skid is full, so no new input competes here
      out_valid_n   = 1'b1;
      out_imm_n     = skid_imm;
      out_fmt_n     = skid_fmt;
      out_illegal_n = skid_illegal;
      out_tag_n     = skid_tag;
      skid_full_n   = 1'b0;
    end else if (acc_in) begin
      out_valid_n   = 1'b1;
      out_imm_n     = dec_imm;
      out_fmt_n     = dec_fmt;
      out_illegal_n = dec_illegal;
      out_tag_n     = in_tag;
    end else begin
      out_valid_n = 1'b0;
    end
    in_ready_n = !skid_full_n;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      out_imm      <= '0;
      out_fmt      <= FMT_NONE;
      out_illegal  <= 1'b0;
      out_tag      <= '0;
      skid_full    <= 1'b0;
      skid_imm     <= '0;
      skid_fmt     <= FMT_NONE;
      skid_illegal <= 1'b0;
      skid_tag     <= '0;
    end else begin
      in_ready     <= in_ready_n;
      out_valid    <= out_valid_n;
      out_imm      <= out_imm_n;
      out_fmt      <= out_fmt_n;
      out_illegal  <= out_illegal_n;
      out_tag      <= out_tag_n;
      skid_full    <= skid_full_n;
      skid_imm     <= skid_imm_n;
      skid_fmt     <= skid_fmt_n;
      skid_illegal <= skid_illegal_n;
      skid_tag     <= skid_tag_n;
    end
  end

`ifdef IMM_GEN_PERF_EN
  logic acc_out;
  assign acc_out = out_valid && out_ready;

  // Saturating handshake counters; cleared only by reset, never by flush.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_total   <= '0;
      perf_illegal <= '0;
    end else begin
      if (acc_out && perf_total != 32'hFFFF_FFFF) begin
        perf_total <= perf_total + 32'd1;
      end
      if (acc_out && out_illegal && perf_illegal != 32'hFFFF_FFFF) begin
        perf_illegal <= perf_illegal + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: decode table on XLEN=32/64 instances plus backpressure, flush and reset sequences.
module tb_imm_gen_pipe;
  import imm_gen_pkg::*;

  localparam int unsigned NV = 14;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_inst = '0;
  logic [31:0] in_tag = '0;

  logic        in_ready, out_valid, out_illegal;
  logic [31:0] out_imm, out_tag;
  imm_fmt_e    out_fmt;
  logic        in_ready64, out_valid64, out_illegal64;
  logic [63:0] out_imm64;
  logic [31:0] out_tag64;
  imm_fmt_e    out_fmt64;
`ifdef IMM_GEN_PERF_EN
  logic [31:0] perf_total, perf_illegal, perf_total64, perf_illegal64;
`endif

  imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm), .out_fmt(out_fmt),
    .out_illegal(out_illegal), .out_tag(out_tag)
`ifdef IMM_GEN_PERF_EN
    , .perf_total(perf_total), .perf_illegal(perf_illegal)
`endif
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64), .in_inst(in_inst), .in_tag(in_tag),
    .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64), .out_fmt(out_fmt64),
    .out_illegal(out_illegal64), .out_tag(out_tag64)
`ifdef IMM_GEN_PERF_EN
    , .perf_total(perf_total64), .perf_illegal(perf_illegal64)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Output handshakes of the XLEN=32 instance, in the order they happen
  logic [31:0] mon_q[$];
  always @(posedge clk) begin
    if (rst_n && out_valid && out_ready) mon_q.push_back(out_tag);
  end

  typedef struct {
    logic [31:0] inst;
    logic [31:0] imm32;
    logic [63:0] imm64;
    imm_fmt_e    fmt;
    logic        ill;
  } vec_t;

  vec_t vecs[NV];

  task automatic push(input logic [31:0] inst, input logic [31:0] tag);
    @(negedge clk);
    in_valid = 1'b1;
    in_inst  = inst;
    in_tag   = tag;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_total;
    int exp_ill;
    exp_total = 0;
    exp_ill   = 0;

    vecs[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, FMT_I,     1'b0}; // addi -1
    vecs[1]  = '{32'h40505093, 32'h00000005, 64'h00000000_00000005, FMT_SHAMT, 1'b0}; // srai 5
    vecs[2]  = '{32'h43F05093, 32'h0000001F, 64'h00000000_0000003F, FMT_SHAMT, 1'b0}; // srai 63 / 31
    vecs[3]  = '{32'hFE112E23, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, FMT_S,     1'b0}; // sw -4
    vecs[4]  = '{32'hFE000CE3, 32'hFFFFFFF8, 64'hFFFFFFFF_FFFFFFF8, FMT_B,     1'b0}; // beq -8
    vecs[5]  = '{32'hFFDFF06F, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, FMT_J,     1'b0}; // jal -4
    vecs[6]  = '{32'h12345037, 32'h12345000, 64'h00000000_12345000, FMT_U,     1'b0}; // lui
    vecs[7]  = '{32'h80000037, 32'h80000000, 64'hFFFFFFFF_80000000, FMT_U,     1'b0}; // lui sign bit
    vecs[8]  = '{32'h002081B3, 32'h00000000, 64'h00000000_00000000, FMT_R,     1'b0}; // add
    vecs[9]  = '{32'h0000007F, 32'h00000000, 64'h00000000_00000000, FMT_NONE,  1'b1}; // bad opcode
    vecs[10] = '{32'h80012083, 32'hFFFFF800, 64'hFFFFFFFF_FFFFF800, FMT_I,     1'b0}; // lw -2048
    vecs[11] = '{32'h004080E7, 32'h00000004, 64'h00000000_00000004, FMT_I,     1'b0}; // jalr 4
    vecs[12] = '{32'hFFF13093, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, FMT_I,     1'b0}; // sltiu -1
    vecs[13] = '{32'h00000000, 32'h00000000, 64'h00000000_00000000, FMT_NONE,  1'b1}; // all zero

    // Reset values, sampled the cycle after release
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst.in_ready",    64'(in_ready),    64'd1);
    chk("rst.out_valid",   64'(out_valid),   64'd0);
    chk("rst.out_imm",     64'(out_imm),     64'd0);
    chk("rst.out_fmt",     64'(out_fmt),     64'(FMT_NONE));
    chk("rst.out_illegal", 64'(out_illegal), 64'd0);
    chk("rst.out_tag",     64'(out_tag),     64'd0);

    // Decode table, back-to-back at full rate
    out_ready = 1'b1;
    for (int i = 0; i < int'(NV); i++) begin
      push(vecs[i].inst, 32'h1000 + 32'(i));
      tick();
      chk($sformatf("v%0d.valid", i),   64'(out_valid),     64'd1);
      chk($sformatf("v%0d.imm", i),     64'(out_imm),       64'(vecs[i].imm32));
      chk($sformatf("v%0d.fmt", i),     64'(out_fmt),       64'(vecs[i].fmt));
      chk($sformatf("v%0d.illegal", i), 64'(out_illegal),   64'(vecs[i].ill));
      chk($sformatf("v%0d.tag", i),     64'(out_tag),       64'h1000 + 64'(i));
      chk($sformatf("v%0d.imm64", i),   out_imm64,          vecs[i].imm64);
      chk($sformatf("v%0d.fmt64", i),   64'(out_fmt64),     64'(vecs[i].fmt));
      chk($sformatf("v%0d.tag64", i),   64'(out_tag64),     64'h1000 + 64'(i));
      exp_total++;
      if (vecs[i].ill) exp_ill++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    tick();
    chk("tbl.drained", 64'(out_valid), 64'd0);
`ifdef IMM_GEN_PERF_EN
    chk("perf.total",   64'(perf_total),   64'(exp_total));
    chk("perf.illegal", 64'(perf_illegal), 64'(exp_ill));
`endif

    // Backpressure: A,B,C back-to-back with out_ready low
    mon_q.delete();
    out_ready = 1'b0;
    push(vecs[0].inst, 32'hA);
    tick();
    chk("bp.a_valid", 64'(out_valid), 64'd1);
    chk("bp.a_tag",   64'(out_tag),   64'hA);
    chk("bp.a_rdy",   64'(in_ready),  64'd1);
    push(vecs[3].inst, 32'hB);
    tick();
    chk("bp.b_rdy",   64'(in_ready),  64'd0);
    chk("bp.b_hold",  64'(out_tag),   64'hA);
    push(vecs[4].inst, 32'hC);
    tick();
    chk("bp.c_rdy",     64'(in_ready),   64'd0);
    chk("bp.c_holdtag", 64'(out_tag),    64'hA);
    chk("bp.c_holdimm", 64'(out_imm),    64'(vecs[0].imm32));
    chk("bp.rdy64",     64'(in_ready64), 64'd0);
    @(negedge clk);
    out_ready = 1'b1;
    tick();
    chk("bp.b_out",  64'(out_tag),  64'hB);
    chk("bp.b_imm",  64'(out_imm),  64'(vecs[3].imm32));
    chk("bp.rdy_up", 64'(in_ready), 64'd1);
    tick();
    chk("bp.c_out",  64'(out_tag),  64'hC);
    chk("bp.c_fmt",  64'(out_fmt),  64'(FMT_B));
    @(negedge clk);
    in_valid = 1'b0;
    tick();
    chk("bp.empty",  64'(out_valid), 64'd0);
    chk("bp.count",  64'(mon_q.size()), 64'd3);
    if (mon_q.size() == 3) begin
      chk("bp.order0", 64'(mon_q[0]), 64'hA);
      chk("bp.order1", 64'(mon_q[1]), 64'hB);
      chk("bp.order2", 64'(mon_q[2]), 64'hC);
    end
    exp_total += 3;

    // Flush with output and skid full plus an input presented
    mon_q.delete();
    out_ready = 1'b0;
    push(vecs[6].inst, 32'hA1);
    tick();
    push(vecs[7].inst, 32'hB1);
    tick();
    push(vecs[8].inst, 32'hC1);
    flush = 1'b1;
    tick();
    chk("fl.valid", 64'(out_valid), 64'd0);
    chk("fl.rdy",   64'(in_ready),  64'd1);
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    chk("fl.still_empty", 64'(out_valid),     64'd0);
    chk("fl.none_out",    64'(mon_q.size()),  64'd0);

    // Flush while in_ready is high: the presented input must still be dropped
    out_ready = 1'b0;
    push(vecs[1].inst, 32'hD1);
    tick();
    push(vecs[2].inst, 32'hE1);
    flush = 1'b1;
    tick();
    chk("fl2.valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) tick();
    chk("fl2.none_out", 64'(mon_q.size()), 64'd0);
`ifdef IMM_GEN_PERF_EN
    chk("perf.flush_total",   64'(perf_total),   64'(exp_total));
    chk("perf.flush_illegal", 64'(perf_illegal), 64'(exp_ill));
`endif

    // Reset mid-stream with an illegal result held in the output stage
    out_ready = 1'b0;
    push(vecs[9].inst, 32'hA2);
    tick();
    chk("mr.pre_illegal", 64'(out_illegal), 64'd1);
    push(vecs[5].inst, 32'hB2);
    tick();
    push(vecs[6].inst, 32'hC2);
    rst_n = 1'b0;
    tick();
    chk("mr.valid",   64'(out_valid),   64'd0);
    chk("mr.rdy",     64'(in_ready),    64'd1);
    chk("mr.imm",     64'(out_imm),     64'd0);
    chk("mr.fmt",     64'(out_fmt),     64'(FMT_NONE));
    chk("mr.illegal", 64'(out_illegal), 64'd0);
    chk("mr.tag",     64'(out_tag),     64'd0);
`ifdef IMM_GEN_PERF_EN
    chk("mr.perf_total",   64'(perf_total),   64'd0);
    chk("mr.perf_illegal", 64'(perf_illegal), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) tick();
    chk("mr.after_valid", 64'(out_valid),    64'd0);
    chk("mr.none_out",    64'(mon_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
